// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - Shared cell type, FSM states and digit/mask helpers for grid_sequencer
package sudoku_pkg;

  typedef logic [8:0] cell_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    SAMPLE,
    SOLVED,
    STALLED,
    ERROR
  } state_t;

  localparam int    N_CELLS  = 81;
  localparam cell_t ALL_CAND = 9'h1FF;

  // Blank cell keeps every candidate open; a given digit pins a single candidate.
  function automatic cell_t digit_to_mask(input logic [3:0] digit);
    cell_t m;
    if (digit == 4'd0) m = ALL_CAND;
    else               m = cell_t'(1) << (digit - 4'd1);
    return m;
  endfunction

  // Resolved cell -> its digit; any cell still holding several candidates reads as 0.
  function automatic logic [3:0] mask_to_digit(input cell_t m);
    logic [3:0] d;
    d = 4'd0;
    if ($onehot(m)) begin
      for (int i = 0; i < 9; i++) begin
        if (m[i]) d = 4'(i + 1);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/grid_unpack.sv
// rtl/grid_unpack.sv - Remaps the box-ordered scanner result into [col][row] cell order
module grid_unpack
  import sudoku_pkg::*;
(
  input  logic [2:0][2:0][8:0][8:0] scan_grid_i,
  output cell_t [8:0][8:0]          grid_o
);

  // Cell k of box (bc,br) sits at column bc*3 + k%3, row br*3 + k/3.
  for (genvar bc = 0; bc < 3; bc++) begin : g_bc
    for (genvar br = 0; br < 3; br++) begin : g_br
      for (genvar k = 0; k < 9; k++) begin : g_k
        assign grid_o[bc*3 + k%3][br*3 + k/3] = scan_grid_i[bc][br][k];
      end
    end
  end

endmodule

// File: rtl/grid_sequencer.sv
// rtl/grid_sequencer.sv - Loads a puzzle and iterates scanner passes; GRID_READBACK_EN adds a result readback stream
module grid_sequencer
  import sudoku_pkg::*;
#(
  parameter int SCAN_LAT = 2,
  parameter int MAX_ITER = 64
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Clear,
  input  logic                      i_Digit_Valid,
  input  logic [3:0]                i_Digit,
  output logic                      o_Digit_Ready,
  output logic [8:0][8:0][8:0]      o_Grid,
  input  logic [2:0][2:0][8:0][8:0] i_Scan_Grid,
  input  logic                      i_Scan_Complete,
  output logic                      o_Busy,
  output logic                      o_Solved,
  output logic                      o_Stalled,
  output logic                      o_Error,
`ifdef GRID_READBACK_EN
  output logic                      o_Out_Valid,
  output logic [3:0]                o_Out_Digit,
  input  logic                      i_Out_Ready,
`endif
  output logic [7:0]                o_Iter
);

  localparam int                   WCW        = (SCAN_LAT > 1) ? $clog2(SCAN_LAT) : 1;
  localparam logic [WCW-1:0]       WCNT_LAST  = WCW'(SCAN_LAT - 1);
  localparam logic [8:0]           ITER_LAST  = 9'(MAX_ITER - 1);
  localparam logic [8:0][8:0][8:0] GRID_RESET = {N_CELLS{ALL_CAND}};

  state_t                state_q, state_d;
  logic [8:0][8:0][8:0]  grid_q, grid_d;
  logic [7:0]            iter_q, iter_d;
  logic [3:0]            col_q, col_d;
  logic [3:0]            row_q, row_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;

  cell_t [8:0][8:0]      scan_cells;
  logic                  scan_has_zero;
  logic                  scan_all_onehot;
  logic                  accept;
  logic                  last_cell;

  grid_unpack u_unpack (
    .scan_grid_i (i_Scan_Grid),
    .grid_o      (scan_cells)
  );

  assign accept    = i_Digit_Valid & o_Digit_Ready;
  assign last_cell = (col_q == 4'd8) && (row_q == 4'd8);
  assign o_Grid    = grid_q;
  assign o_Iter    = iter_q;

  // Scanner result health: a dead cell means a contradiction, all one-hot means fully resolved.
  always_comb begin
    scan_has_zero   = 1'b0;
    scan_all_onehot = 1'b1;
    for (int c = 0; c < 9; c++) begin
      for (int r = 0; r < 9; r++) begin
        if (scan_cells[c][r] == '0)    scan_has_zero   = 1'b1;
        if (!$onehot(scan_cells[c][r])) scan_all_onehot = 1'b0;
      end
    end
  end

  // Next-state and datapath update; clear overrides everything including a live handshake.
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    iter_d  = iter_q;
    col_d   = col_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    if (i_Clear) begin
      state_d = IDLE;
      grid_d  = GRID_RESET;
      iter_d  = '0;
      col_d   = '0;
      row_d   = '0;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (i_Digit > 4'd9) begin
              state_d = ERROR;
            end else begin
              grid_d[col_q][row_q] = digit_to_mask(i_Digit);
              if (col_q == 4'd8) begin
                col_d = '0;
                row_d = row_q + 4'd1;
              end else begin
                col_d = col_q + 4'd1;
              end
              if (last_cell) begin
                state_d = WAIT;
                wcnt_d  = '0;
              end else begin
                state_d = LOAD;
              end
            end
          end
        end
        WAIT: begin
          if (wcnt_q == WCNT_LAST) state_d = SAMPLE;
          else                     wcnt_d  = wcnt_q + WCW'(1);
        end
        SAMPLE: begin
          if (scan_has_zero) begin
            state_d = ERROR;
          end else if (i_Scan_Complete && scan_all_onehot) begin
            state_d = SOLVED;
          end else if (scan_cells == grid_q) begin
            state_d = STALLED;
          end else begin
            grid_d = scan_cells;
            if (iter_q != 8'hFF) iter_d = iter_q + 8'd1;
            if ({1'b0, iter_q} == ITER_LAST) begin
              state_d = STALLED;
            end else begin
              state_d = WAIT;
              wcnt_d  = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM register; status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q       <= IDLE;
      grid_q        <= GRID_RESET;
      iter_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      wcnt_q        <= '0;
      o_Digit_Ready <= 1'b1;
      o_Busy        <= 1'b0;
      o_Solved      <= 1'b0;
      o_Stalled     <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grid_q        <= grid_d;
      iter_q        <= iter_d;
      col_q         <= col_d;
      row_q         <= row_d;
      wcnt_q        <= wcnt_d;
      o_Digit_Ready <= (state_d == IDLE) || (state_d == LOAD);
      o_Busy        <= (state_d == LOAD) || (state_d == WAIT) || (state_d == SAMPLE);
      o_Solved      <= (state_d == SOLVED);
      o_Stalled     <= (state_d == STALLED);
      o_Error       <= (state_d == ERROR);
    end
  end

`ifdef GRID_READBACK_EN
  logic       rb_active_q;
  logic [3:0] rb_col_q;
  logic [3:0] rb_row_q;
  logic       rb_start;

  assign rb_start = ((state_d == SOLVED) || (state_d == STALLED)) &&
                    (state_q != SOLVED) && (state_q != STALLED);

  // Walk the final grid row-major, one cell per accepted output digit.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      rb_active_q <= 1'b0;
      rb_col_q    <= '0;
      rb_row_q    <= '0;
    end else if (i_Clear) begin
      rb_active_q <= 1'b0;
      rb_col_q    <= '0;
      rb_row_q    <= '0;
    end else if (rb_start) begin
      rb_active_q <= 1'b1;
      rb_col_q    <= '0;
      rb_row_q    <= '0;
    end else if (rb_active_q && i_Out_Ready) begin
      if (rb_col_q == 4'd8) begin
        rb_col_q <= '0;
        if (rb_row_q == 4'd8) rb_active_q <= 1'b0;
        else                  rb_row_q    <= rb_row_q + 4'd1;
      end else begin
        rb_col_q <= rb_col_q + 4'd1;
      end
    end
  end

  // Grid is frozen in terminal states, so the digit only moves when the pointer advances.
  assign o_Out_Valid = rb_active_q;
  assign o_Out_Digit = mask_to_digit(grid_q[rb_col_q][rb_row_q]);
`endif

endmodule

// File: tb/tb_grid_sequencer.sv
// tb/tb_grid_sequencer.sv - Directed self-checking bench for grid_sequencer with a model scanner
module tb_grid_sequencer;

  typedef logic [8:0][8:0][8:0]      grid_t;
  typedef logic [2:0][2:0][8:0][8:0] sgrid_t;

  logic                   i_Clk = 1'b0;
  logic                   i_Reset = 1'b0;
  logic                   i_Clear = 1'b0;
  logic                   i_Digit_Valid = 1'b0;
  logic [3:0]             i_Digit = 4'd0;
  logic                   o_Digit_Ready;
  grid_t                  o_Grid;
  sgrid_t                 i_Scan_Grid;
  logic                   i_Scan_Complete;
  logic                   o_Busy, o_Solved, o_Stalled, o_Error;
  logic [7:0]             o_Iter;
`ifdef GRID_READBACK_EN
  logic                   o_Out_Valid;
  logic [3:0]             o_Out_Digit;
  logic                   i_Out_Ready = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int scan_mode = 0;
  grid_t all_grid;
  grid_t sol_grid;

  int sol [81] = '{5,3,4,6,7,8,9,1,2,
                   6,7,2,1,9,5,3,4,8,
                   1,9,8,3,4,2,5,6,7,
                   8,5,9,7,6,1,4,2,3,
                   4,2,6,8,5,3,7,9,1,
                   7,1,3,9,2,4,8,5,6,
                   9,6,1,5,3,7,2,8,4,
                   2,8,7,4,1,9,6,3,5,
                   3,4,5,2,8,6,1,7,9};

  grid_sequencer #(.SCAN_LAT(2), .MAX_ITER(64)) dut (
    .i_Clk           (i_Clk),
    .i_Reset         (i_Reset),
    .i_Clear         (i_Clear),
    .i_Digit_Valid   (i_Digit_Valid),
    .i_Digit         (i_Digit),
    .o_Digit_Ready   (o_Digit_Ready),
    .o_Grid          (o_Grid),
    .i_Scan_Grid     (i_Scan_Grid),
    .i_Scan_Complete (i_Scan_Complete),
    .o_Busy          (o_Busy),
    .o_Solved        (o_Solved),
    .o_Stalled       (o_Stalled),
    .o_Error         (o_Error),
`ifdef GRID_READBACK_EN
    .o_Out_Valid     (o_Out_Valid),
    .o_Out_Digit     (o_Out_Digit),
    .i_Out_Ready     (i_Out_Ready),
`endif
    .o_Iter          (o_Iter)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mask_of(input int d);
    return (d == 0) ? 9'h1FF : 9'(1 << (d - 1));
  endfunction

  function automatic logic [3:0] puz(input int n);
    return ((n % 9) == (n / 9)) ? 4'd0 : 4'(sol[n]);
  endfunction

  function automatic bit all_onehot(input grid_t g);
    bit ok;
    ok = 1'b1;
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 9; r++)
        if (!$onehot(g[c][r])) ok = 1'b0;
    return ok;
  endfunction

  // One elimination sweep: resolved peers remove their digit from unresolved cells.
  function automatic grid_t eliminate(input grid_t g);
    grid_t o;
    o = g;
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 9; r++)
        if (!$onehot(g[c][r]))
          for (int c2 = 0; c2 < 9; c2++)
            for (int r2 = 0; r2 < 9; r2++)
              if ((c2 != c || r2 != r) &&
                  (c2 == c || r2 == r || (c2 / 3 == c / 3 && r2 / 3 == r / 3)) &&
                  $onehot(g[c2][r2]))
                o[c][r] = o[c][r] & ~g[c2][r2];
    return o;
  endfunction

  function automatic sgrid_t pack(input grid_t g);
    sgrid_t s;
    for (int bc = 0; bc < 3; bc++)
      for (int br = 0; br < 3; br++)
        for (int k = 0; k < 9; k++)
          s[bc][br][k] = g[bc*3 + k%3][br*3 + k/3];
    return s;
  endfunction

  function automatic int grid_diff(input grid_t exp);
    int n;
    n = 0;
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 9; r++)
        if (o_Grid[c][r] !== exp[c][r]) n++;
    return n;
  endfunction

  // Model scanner: mode 0 echoes, 1 eliminates, 2 eliminates then kills cell [4][4].
  always_comb begin
    grid_t g;
    g = o_Grid;
    if (scan_mode != 0) g = eliminate(g);
    if (scan_mode == 2) g[4][4] = 9'h000;
    i_Scan_Grid     = pack(g);
    i_Scan_Complete = all_onehot(o_Grid);
  end

  task automatic send(input logic [3:0] d);
    i_Digit_Valid = 1'b1;
    i_Digit       = d;
    @(negedge i_Clk);
  endtask

  task automatic load(input int first, input int last, input bit zeros);
    for (int n = first; n <= last; n++) send(zeros ? 4'd0 : puz(n));
    i_Digit_Valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!(o_Solved || o_Stalled || o_Error) && cyc < 500) begin
      @(negedge i_Clk);
      cyc++;
    end
    check("done_in_time", 32'(cyc < 500), 1);
  endtask

  task automatic pulse_clear();
    i_Clear = 1'b1;
    @(negedge i_Clk);
    i_Clear = 1'b0;
  endtask

`ifdef GRID_READBACK_EN
  logic [3:0] rb_q[$];
  logic       rb_chk = 1'b0;
  logic       rb_r;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_digit = 4'd0;

  // Random backpressure on the readback port; capture handshakes and verify hold while stalled.
  always @(negedge i_Clk) begin
    if (prev_stall) begin
      check("rb_hold_valid", o_Out_Valid, 1);
      check("rb_hold_digit", o_Out_Digit, prev_digit);
    end
    rb_r = 1'($urandom_range(0, 1));
    i_Out_Ready <= rb_r;
    if (rb_chk && o_Out_Valid && rb_r) rb_q.push_back(o_Out_Digit);
    prev_stall <= rb_chk && o_Out_Valid && !rb_r;
    prev_digit <= o_Out_Digit;
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nbad;
    all_grid = {81{9'h1FF}};
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 9; r++)
        sol_grid[c][r] = mask_of(sol[r*9 + c]);

    repeat (2) @(negedge i_Clk);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    check("rst_ready", o_Digit_Ready, 1);
    check("rst_busy", o_Busy, 0);
    check("rst_solved", o_Solved, 0);
    check("rst_stalled", o_Stalled, 0);
    check("rst_error", o_Error, 0);
    check("rst_iter", o_Iter, 0);
    check("rst_grid", grid_diff(all_grid), 0);

    i_Clear = 1'b1; i_Digit_Valid = 1'b1; i_Digit = 4'd5;
    @(negedge i_Clk);
    i_Clear = 1'b0; i_Digit_Valid = 1'b0;
    check("clr_prio_cell", o_Grid[0][0], 9'h1FF);
    check("clr_prio_busy", o_Busy, 0);

    scan_mode = 0;
    load(0, 80, 1'b1);
    check("zero_busy", o_Busy, 1);
    check("zero_ready", o_Digit_Ready, 0);
    wait_done(cyc);
    check("stall_latency", cyc, 3);
    check("zero_stalled", o_Stalled, 1);
    check("zero_solved", o_Solved, 0);
    check("zero_iter", o_Iter, 0);
    check("zero_busy_end", o_Busy, 0);
    pulse_clear();
    check("clr1_ready", o_Digit_Ready, 1);
    check("clr1_stalled", o_Stalled, 0);

    scan_mode = 1;
`ifdef GRID_READBACK_EN
    rb_q.delete();
    rb_chk = 1'b1;
`endif
    load(0, 80, 1'b0);
    wait_done(cyc);
    check("solve_latency", cyc, 6);
    check("solve_solved", o_Solved, 1);
    check("solve_stalled", o_Stalled, 0);
    check("solve_error", o_Error, 0);
    check("solve_iter", o_Iter, 1);
    check("solve_grid", grid_diff(sol_grid), 0);
`ifdef GRID_READBACK_EN
    for (int i = 0; i < 1000 && rb_q.size() < 81; i++) @(negedge i_Clk);
    repeat (20) @(negedge i_Clk);
    rb_chk = 1'b0;
    @(negedge i_Clk);
    check("rb_count", rb_q.size(), 81);
    nbad = 0;
    for (int i = 0; i < 81; i++)
      if (i >= rb_q.size() || rb_q[i] !== 4'(sol[i])) nbad++;
    check("rb_digits", nbad, 0);
`endif
    pulse_clear();
    scan_mode = 0;

    load(0, 4, 1'b0);
    send(4'd12);
    i_Digit_Valid = 1'b0;
    check("baddig_error", o_Error, 1);
    check("baddig_ready", o_Digit_Ready, 0);
    check("baddig_busy", o_Busy, 0);
    check("baddig_cell5", o_Grid[5][0], 9'h1FF);
    check("baddig_cell4", o_Grid[4][0], 9'h040);
    @(negedge i_Clk);
    check("baddig_hold", o_Error, 1);
    pulse_clear();

    scan_mode = 2;
    load(0, 80, 1'b0);
    wait_done(cyc);
    check("zcell_error", o_Error, 1);
    check("zcell_stalled", o_Stalled, 0);
    check("zcell_grid_kept", grid_diff(all_grid), 72);
    pulse_clear();
    check("zcell_clr_ready", o_Digit_Ready, 1);
    check("zcell_clr_error", o_Error, 0);
    check("zcell_clr_grid", grid_diff(all_grid), 0);
    check("zcell_clr_iter", o_Iter, 0);
    scan_mode = 0;

    load(0, 39, 1'b0);
    check("mid_busy", o_Busy, 1);
    i_Reset = 1'b0;
    #1;
    check("arst_ready", o_Digit_Ready, 1);
    check("arst_busy", o_Busy, 0);
    check("arst_flags", {o_Solved, o_Stalled, o_Error}, 0);
    check("arst_iter", o_Iter, 0);
    check("arst_grid", grid_diff(all_grid), 0);
    @(negedge i_Clk);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    send(4'd7);
    i_Digit_Valid = 1'b0;
    check("reload_cell00", o_Grid[0][0], 9'h040);
    check("reload_cell10", o_Grid[1][0], 9'h1FF);
    check("reload_busy", o_Busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_sequencer.md
GRID_SEQUENCER -- requirements
Module: grid_sequencer

Interface
REQ-001 SHALL have parameter SCAN_LAT, default 2: cycles to wait after a grid write before sampling the scanner result.
REQ-002 SHALL have parameter MAX_ITER, default 64: maximum number of scanner passes before the solve is abandoned.
REQ-003 SHALL have port i_Clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_Clear, input, 1 bit: synchronous return to IDLE from any state.
REQ-006 SHALL have port i_Digit_Valid, input, 1 bit: a puzzle digit is offered.
REQ-007 SHALL have port i_Digit, input, 4 bits: 0 means blank, 1-9 means given, 10-15 is illegal.
REQ-008 SHALL have port o_Digit_Ready, output, 1 bit: a digit is accepted when valid and ready are both high.
REQ-009 SHALL have port o_Grid, output, [8:0][8:0][8:0]: candidate masks indexed [col][row], driving the scanner grid input.
REQ-010 SHALL have port i_Scan_Grid, input, [2:0][2:0][8:0][8:0]: scanner result, indexed [box_col][box_row][k].
REQ-011 SHALL have port i_Scan_Complete, input, 1 bit: scanner completion flag.
REQ-012 SHALL have port o_Busy, output, 1 bit: high in LOAD, WAIT and SAMPLE.
REQ-013 SHALL have ports o_Solved, o_Stalled and o_Error, outputs, 1 bit each: terminal status flags.
REQ-014 SHALL have port o_Iter, output, 8 bits: number of completed write-back passes.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WAIT, SAMPLE, SOLVED, STALLED and ERROR.
REQ-016 SHALL drive o_Digit_Ready high only in IDLE and LOAD.
REQ-017 SHALL write the n-th accepted digit to cell col = n%9, row = n/9, with n running 0..80.
REQ-018 SHALL map digit 0 to 9'h1FF and digit d in 1-9 to 1<<(d-1).
REQ-019 SHALL enter ERROR on an accepted digit of 10-15; the cell is not written.
REQ-020 SHALL move IDLE->LOAD on the first accepted digit and LOAD->WAIT on the acceptance of digit 80.
REQ-021 SHALL stay in WAIT for exactly SCAN_LAT cycles, then enter SAMPLE.
REQ-022 SHALL remap i_Scan_Grid[bc][br][k] to cell col = bc*3 + k%3, row = br*3 + k/3.
REQ-023 SHALL evaluate SAMPLE in one cycle, in priority order:
  - any remapped cell equal to 0 -> ERROR;
  - i_Scan_Complete high and every cell one-hot -> SOLVED;
  - remapped grid equal to o_Grid -> STALLED;
  - o_Iter+1 equal to MAX_ITER -> write back, then STALLED;
  - otherwise write the remapped grid to o_Grid, increment o_Iter, and enter WAIT.
REQ-024 SHALL hold SOLVED, STALLED and ERROR until i_Clear; the terminal flags are high only in their own state.
REQ-025 SHALL on i_Clear set o_Grid to all 9'h1FF, o_Iter to 0 and the digit index to 0, and enter IDLE; i_Clear takes priority over a simultaneous digit handshake.
REQ-026 SHALL saturate o_Iter and never wrap it.

Reset
REQ-027 SHALL on i_Reset low asynchronously set:
  - the state to IDLE;
  - o_Grid to all 9'h1FF;
  - o_Iter and the digit index to 0;
  - o_Solved, o_Stalled, o_Error and o_Busy to 0;
  - o_Digit_Ready to 1.
REQ-028 SHALL discard a partially loaded puzzle when reset is asserted during LOAD; after reset, loading restarts at cell 0.

Configuration
REQ-029 SHALL compile readback logic only when GRID_READBACK_EN is defined.
REQ-030 With GRID_READBACK_EN defined, SHALL add ports:
  - o_Out_Valid, output, 1 bit;
  - o_Out_Digit, output, 4 bits;
  - i_Out_Ready, input, 1 bit.
REQ-031 With GRID_READBACK_EN defined, SHALL stream 81 digits in row-major order once on entry to SOLVED or STALLED.
  - Each digit is the one-hot index + 1, or 0 for a multi-candidate cell.
  - o_Out_Digit is held stable while o_Out_Valid is high and i_Out_Ready is low.
  - i_Clear aborts the stream.
REQ-032 Without GRID_READBACK_EN, SHALL have none of these ports and no readback logic.

Structure
REQ-033 SHALL take the following from shared package sudoku_pkg:
  - typedef cell_t (9 bits);
  - the FSM state enum;
  - constants N_CELLS = 81 and ALL_CAND = 9'h1FF.
REQ-034 SHALL perform the box-to-[col][row] remap in a combinational sub-module, grid_unpack.

Verification
REQ-035 SHALL load 81 zeros -> reach SAMPLE; scanner returns an unchanged grid -> o_Stalled=1, o_Iter=0.
REQ-036 SHALL load a valid puzzle with a model scanner -> o_Solved=1 within MAX_ITER passes, and o_Grid matches the known solution.
REQ-037 SHALL send digit 12 at n=5 -> o_Error=1 next cycle, and o_Digit_Ready=0.
REQ-038 SHALL have the scanner return cell [4][4]=0 -> o_Error=1; then i_Clear -> IDLE with o_Grid all 9'h1FF.
REQ-039 SHALL assert i_Reset low at n=40 -> all outputs at reset values; a reload then writes cell [0][0] first.
REQ-040 SHALL with GRID_READBACK_EN, toggle i_Out_Ready randomly -> exactly 81 digits delivered in order, each stable while stalled.
